// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: walks ProgCtr through program memory from PROG_START,
// applying stalls, absolute/relative branches and halt, and counts advancing cycles.
module ifetch_ctrl #(
  parameter logic [10:0] PROG_START = 11'd0,
  parameter logic [10:0] LAST_ADDR  = 11'd2047
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  input  logic        Stall,
  input  logic        BranchAbs,
  input  logic        BranchRel,
  input  logic [10:0] Target,
  input  logic [7:0]  Offset,
  output logic [10:0] ProgCtr,
  output logic        Running,
  output logic        Ack,
  output logic [15:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] rel_target;

  assign rel_target = pc_q + {{3{Offset[7]}}, Offset};

  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = PROG_START;
          cnt_d   = 16'd0;
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = DONE;
        end else if (!Stall) begin
          // Any non-halted, non-stalled cycle advances, including the one that runs off the end.
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (BranchAbs) begin
            pc_d = Target;
          end else if (BranchRel) begin
            pc_d = rel_target;
          end else if (pc_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + 11'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = PROG_START;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= PROG_START;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign InstCount = cnt_q;
  assign Running   = (state_q == RUN);
  assign Ack       = (state_q == DONE);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed, table-driven bench for ifetch_ctrl with hand-written multi-cycle sequences.
module tb_ifetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt, Stall, BranchAbs, BranchRel;
  logic [10:0] Target;
  logic [7:0]  Offset;
  logic [10:0] ProgCtr;
  logic        Running, Ack;
  logic [15:0] InstCount;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        rst, start, halt, stall, babs, brel;
    logic [10:0] target;
    logic [7:0]  offset;
    logic [10:0] exp_pc;
    logic        exp_run, exp_ack;
    logic [15:0] exp_cnt;
  } vec_t;

  ifetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Target(Target), .Offset(Offset),
    .ProgCtr(ProgCtr), .Running(Running), .Ack(Ack), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mkv(string name, logic rst, logic start, logic halt, logic stall,
                               logic babs, logic brel, logic [10:0] target, logic [7:0] offset,
                               logic [10:0] exp_pc, logic exp_run, logic exp_ack,
                               logic [15:0] exp_cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.start = start; v.halt = halt; v.stall = stall;
    v.babs = babs; v.brel = brel; v.target = target; v.offset = offset;
    v.exp_pc = exp_pc; v.exp_run = exp_run; v.exp_ack = exp_ack; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge Clk);
    Reset = v.rst; Start = v.start; Halt = v.halt; Stall = v.stall;
    BranchAbs = v.babs; BranchRel = v.brel; Target = v.target; Offset = v.offset;
    @(posedge Clk);
    #1;
    check({v.name, ".pc"},  {5'd0, ProgCtr}, {5'd0, v.exp_pc});
    check({v.name, ".run"}, {15'd0, Running}, {15'd0, v.exp_run});
    check({v.name, ".ack"}, {15'd0, Ack},     {15'd0, v.exp_ack});
    check({v.name, ".cnt"}, InstCount, v.exp_cnt);
  endtask

  vec_t tbl[19];

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
    BranchAbs = 1'b0; BranchRel = 1'b0; Target = '0; Offset = '0;

    //                 name        rst st hl sl ba br target  offset  pc      run ack cnt
    tbl[0]  = mkv("reset",        1, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd0,    0, 0, 16'd0);
    tbl[1]  = mkv("idle_wait",    0, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd0,    0, 0, 16'd0);
    tbl[2]  = mkv("idle_ignore",  0, 0, 1, 0, 1, 0, 11'd55,  8'h00,  11'd0,    0, 0, 16'd0);
    tbl[3]  = mkv("start",        0, 1, 0, 0, 0, 0, 11'd0,   8'h00,  11'd0,    1, 0, 16'd0);
    tbl[4]  = mkv("seq1",         0, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd1,    1, 0, 16'd1);
    tbl[5]  = mkv("seq2",         0, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd2,    1, 0, 16'd2);
    tbl[6]  = mkv("seq3",         0, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd3,    1, 0, 16'd3);
    tbl[7]  = mkv("seq4",         0, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd4,    1, 0, 16'd4);
    tbl[8]  = mkv("seq5",         0, 0, 0, 0, 0, 0, 11'd0,   8'h00,  11'd5,    1, 0, 16'd5);
    tbl[9]  = mkv("run_start_ig", 0, 1, 0, 0, 0, 0, 11'd0,   8'h00,  11'd6,    1, 0, 16'd6);
    tbl[10] = mkv("babs10",       0, 0, 0, 0, 1, 0, 11'd10,  8'h00,  11'd10,   1, 0, 16'd7);
    tbl[11] = mkv("babs100",      0, 0, 0, 0, 1, 0, 11'd100, 8'h00,  11'd100,  1, 0, 16'd8);
    tbl[12] = mkv("brel_m4",      0, 0, 0, 0, 0, 1, 11'd0,   8'hFC,  11'd96,   1, 0, 16'd9);
    tbl[13] = mkv("abs_over_rel", 0, 0, 0, 0, 1, 1, 11'd7,   8'h05,  11'd7,    1, 0, 16'd10);
    tbl[14] = mkv("halt_prio",    0, 0, 1, 1, 1, 0, 11'd300, 8'h00,  11'd7,    0, 1, 16'd10);
    tbl[15] = mkv("done_hold",    0, 0, 1, 0, 1, 0, 11'd9,   8'h00,  11'd7,    0, 1, 16'd10);
    tbl[16] = mkv("restart",      0, 1, 0, 0, 0, 0, 11'd0,   8'h00,  11'd0,    1, 0, 16'd0);
    tbl[17] = mkv("brel_wrap_dn", 0, 0, 0, 0, 0, 1, 11'd0,   8'hFF,  11'd2047, 1, 0, 16'd1);
    tbl[18] = mkv("brel_wrap_up", 0, 0, 0, 0, 0, 1, 11'd0,   8'h01,  11'd0,    1, 0, 16'd2);

    for (int i = 0; i < 19; i++) step(tbl[i]);

    // Stall held three cycles at 20, then release.
    step(mkv("to20",   0, 0, 0, 0, 1, 0, 11'd20, 8'h00, 11'd20, 1, 0, 16'd3));
    for (int i = 0; i < 3; i++)
      step(mkv("stall", 0, 0, 0, 1, 0, 0, 11'd0, 8'h00, 11'd20, 1, 0, 16'd3));
    step(mkv("unstall", 0, 0, 0, 0, 0, 0, 11'd0, 8'h00, 11'd21, 1, 0, 16'd4));

    // Running off the end of memory.
    step(mkv("to2047", 0, 0, 0, 0, 1, 0, 11'd2047, 8'h00, 11'd2047, 1, 0, 16'd5));
    step(mkv("eom",    0, 0, 0, 0, 0, 0, 11'd0,    8'h00, 11'd2047, 0, 1, 16'd6));

    // A branch from the last address is taken normally.
    step(mkv("restart2",  0, 1, 0, 0, 0, 0, 11'd0,    8'h00, 11'd0,    1, 0, 16'd0));
    step(mkv("to2047b",   0, 0, 0, 0, 1, 0, 11'd2047, 8'h00, 11'd2047, 1, 0, 16'd1));
    step(mkv("brel_last", 0, 0, 0, 0, 0, 1, 11'd0,    8'h01, 11'd0,    1, 0, 16'd2));

    // Reset mid-run overrides Start and aborts without Ack.
    step(mkv("to50",      0, 0, 0, 0, 1, 0, 11'd50, 8'h00, 11'd50, 1, 0, 16'd3));
    step(mkv("rst_run",   1, 1, 0, 0, 0, 0, 11'd0,  8'h00, 11'd0,  0, 0, 16'd0));
    step(mkv("post_rst",  0, 0, 0, 0, 1, 0, 11'd9,  8'h00, 11'd0,  0, 0, 16'd0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The block SHALL have parameter PROG_START, default 11'd0, meaning the address loaded into ProgCtr on every program start.
REQ-002 The block SHALL have parameter LAST_ADDR, default 11'd2047, meaning the highest fetchable address; sequential fetch past it ends the program.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Start, input, 1 bit: request to begin a program from PROG_START.
REQ-006 The block SHALL have port Halt, input, 1 bit: decoded halt instruction; ends the program.
REQ-007 The block SHALL have port Stall, input, 1 bit: hold the current fetch address this cycle.
REQ-008 The block SHALL have port BranchAbs, input, 1 bit: taken absolute branch.
REQ-009 The block SHALL have port BranchRel, input, 1 bit: taken PC-relative branch.
REQ-010 The block SHALL have port Target, input, 11 bits: absolute branch destination.
REQ-011 The block SHALL have port Offset, input, 8 bits: two's-complement relative branch offset.
REQ-012 The block SHALL have port ProgCtr, output, 11 bits: registered fetch address, driving the instruction memory address input.
REQ-013 The block SHALL have port Running, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port Ack, output, 1 bit: high while in DONE (program complete).
REQ-015 The block SHALL have port InstCount, output, 16 bits: count of advancing RUN cycles in the current program.

Function
REQ-016 The block SHALL implement three states: IDLE, RUN, DONE. All outputs SHALL be registered or decoded from state only.
REQ-017 In IDLE or DONE, Start=1 SHALL move to RUN on the next edge, load ProgCtr=PROG_START, and clear InstCount to 0. Ack SHALL drop in that same edge.
REQ-018 In RUN, Start SHALL be ignored.
REQ-019 In RUN, next ProgCtr SHALL be chosen by fixed priority:
  - Halt: go to DONE, hold ProgCtr.
  - Stall: hold ProgCtr.
  - BranchAbs: ProgCtr = Target.
  - BranchRel: ProgCtr = ProgCtr + sign-extended Offset, modulo 2^11.
  - Otherwise: ProgCtr + 1.
REQ-020 In RUN, a plain increment with ProgCtr == LAST_ADDR SHALL go to DONE and hold ProgCtr. A branch from LAST_ADDR SHALL be taken normally.
REQ-021 BranchRel SHALL wrap silently: 11'd2047 + 1 = 11'd0, and 11'd0 + (-1) = 11'd2047.
REQ-022 InstCount SHALL increment on every RUN cycle not consumed by Halt or Stall, and SHALL saturate at 16'hFFFF.
REQ-023 Halt, Stall and branch inputs SHALL be ignored outside RUN.
REQ-024 Simultaneous BranchAbs and BranchRel SHALL take BranchAbs only.
REQ-025 Running SHALL be 1 exactly in RUN, and Ack SHALL be 1 exactly in DONE; the two SHALL never both be 1.

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE, ProgCtr=PROG_START, InstCount=0, Running=0 and Ack=0, overriding all other inputs including Start.
REQ-027 Reset asserted mid-RUN SHALL abort the program with no Ack pulse.
REQ-028 After Reset is released, the block SHALL wait in IDLE for Start.

Verification
REQ-029 Sequential run: Reset, then Start for 1 cycle, then 5 idle cycles -> ProgCtr steps 0,1,2,3,4,5; Running=1; InstCount=5.
REQ-030 Branches:
  - At ProgCtr=10, BranchAbs=1 with Target=100 -> ProgCtr=100.
  - Then BranchRel=1 with Offset=8'hFC -> ProgCtr=96.
  - At ProgCtr=0, BranchRel=1 with Offset=8'hFF -> ProgCtr=2047.
REQ-031 Priority: at ProgCtr=7, Halt=1 with Stall=1 and BranchAbs=1 -> DONE, ProgCtr=7, Ack=1, Running=0. Then Start=1 -> ProgCtr=0, Ack=0, InstCount=0.
REQ-032 Stall: hold Stall for 3 cycles at ProgCtr=20 -> ProgCtr=20 and InstCount unchanged for all 3 cycles; ProgCtr=21 on the first cycle after release.
REQ-033 End of memory: BranchAbs to 2047, then 1 idle cycle -> DONE with ProgCtr=2047 and Ack=1.
REQ-034 Reset mid-run: at ProgCtr=50 assert Reset together with Start -> IDLE, ProgCtr=0, Ack=0, Running=0.
